// File: rtl/mips_mem_arbiter.sv
// Arbiter sharing one single-ported synchronous memory between the fetch (IF) and
// load/store (DM) ports of mips_core, with at most one access outstanding.
module mips_mem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MEM_LATENCY  = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned LAT_W = $clog2(MEM_LATENCY + 1);
  localparam int unsigned SC_W  = $clog2(STARVE_LIMIT + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  logic [0:0]      state;
  logic [0:0]      next_state;
  logic [LAT_W-1:0] lat_cnt;
  logic [SC_W-1:0]  starve_cnt;
  logic            owner;
  logic            lat_done;
  logic            starve_full;

  assign lat_done    = (state == BUSY) && (lat_cnt == LAT_W'(MEM_LATENCY));
  assign starve_full = (starve_cnt == SC_W'(STARVE_LIMIT));
  assign busy        = (state == BUSY);
  assign if_rdata    = mem_rdata;
  assign dm_rdata    = mem_rdata;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Grant selection, memory mux and completion pulses; everything quiet while in reset
  always_comb begin
    next_state = state;
    if_gnt     = 1'b0;
    dm_gnt     = 1'b0;
    if_rvalid  = 1'b0;
    dm_rvalid  = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (reset) begin
      case (state)
        IDLE: begin
          if (if_req && (!dm_req || starve_full)) begin
            if_gnt     = 1'b1;
            mem_en     = 1'b1;
            mem_addr   = if_addr;
            next_state = BUSY;
          end else if (dm_req) begin
            dm_gnt     = 1'b1;
            mem_en     = 1'b1;
            mem_we     = dm_we;
            mem_addr   = dm_addr;
            mem_wdata  = dm_wdata;
            next_state = BUSY;
          end
        end
        BUSY: begin
          if (lat_done) begin
            if_rvalid  = (owner == OWN_IF);
            dm_rvalid  = (owner == OWN_DM);
            next_state = IDLE;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // Access owner, latency counter and fetch anti-starvation counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner      <= OWN_IF;
      lat_cnt    <= '0;
      starve_cnt <= '0;
    end else begin
      if (if_gnt) begin
        owner   <= OWN_IF;
        lat_cnt <= LAT_W'(1);
      end else if (dm_gnt) begin
        owner   <= OWN_DM;
        lat_cnt <= LAT_W'(1);
      end else if (lat_done) begin
        lat_cnt <= '0;
      end else if (state == BUSY) begin
        lat_cnt <= lat_cnt + LAT_W'(1);
      end

      if (!if_req || if_gnt) begin
        starve_cnt <= '0;
      end else if (dm_gnt && !starve_full) begin
        starve_cnt <= starve_cnt + SC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter: reset, lone fetch, store, contention with
// starvation limit, owner-routed rvalid and mid-access reset.
module tb_mips_mem_arbiter;

  logic        clock;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;

  int vectors;
  int miscompares;

  mips_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(2), .STARVE_LIMIT(4)
  ) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    if_req      = 1'b1;
    if_addr     = 32'h0000_0010;
    dm_req      = 1'b1;
    dm_we       = 1'b0;
    dm_addr     = 32'h0000_0200;
    dm_wdata    = 32'h0;
    mem_rdata   = 32'h0;

    // 1. reset held with both requests
    cyc(); cyc();
    #1;
    check("rst_if_gnt",    32'(if_gnt),    32'd0);
    check("rst_dm_gnt",    32'(dm_gnt),    32'd0);
    check("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    check("rst_dm_rvalid", 32'(dm_rvalid), 32'd0);
    check("rst_mem_en",    32'(mem_en),    32'd0);
    check("rst_mem_we",    32'(mem_we),    32'd0);
    check("rst_busy",      32'(busy),      32'd0);

    cyc(); reset = 1'b1; #1;
    check("rel_dm_gnt",   32'(dm_gnt), 32'd1);
    check("rel_if_gnt",   32'(if_gnt), 32'd0);
    check("rel_mem_en",   32'(mem_en), 32'd1);
    check("rel_mem_addr", mem_addr,    32'h0000_0200);
    cyc(); if_req = 1'b0; dm_req = 1'b0; #1;
    check("rel_busy_t1", 32'(busy), 32'd1);
    cyc(); #1;
    check("rel_dm_rvalid", 32'(dm_rvalid), 32'd1);
    check("rel_if_rvalid", 32'(if_rvalid), 32'd0);

    // 2. lone fetch
    cyc(); if_req = 1'b1; if_addr = 32'h0000_0040; #1;
    check("f_if_gnt",   32'(if_gnt), 32'd1);
    check("f_mem_en",   32'(mem_en), 32'd1);
    check("f_mem_addr", mem_addr,    32'h0000_0040);
    check("f_mem_we",   32'(mem_we), 32'd0);
    check("f_mem_wdata", mem_wdata,  32'h0);
    cyc(); if_req = 1'b0; #1;
    check("f_busy_t1",    32'(busy),      32'd1);
    check("f_rvalid_t1",  32'(if_rvalid), 32'd0);
    check("f_mem_en_t1",  32'(mem_en),    32'd0);
    cyc(); mem_rdata = 32'h2008_0005; #1;
    check("f_if_rvalid", 32'(if_rvalid), 32'd1);
    check("f_if_rdata",  if_rdata,       32'h2008_0005);
    check("f_dm_rvalid", 32'(dm_rvalid), 32'd0);

    // 3. store
    cyc(); mem_rdata = 32'h0; dm_req = 1'b1; dm_we = 1'b1;
    dm_addr = 32'h0000_0100; dm_wdata = 32'hDEAD_BEEF; #1;
    check("s_dm_gnt",    32'(dm_gnt), 32'd1);
    check("s_mem_we",    32'(mem_we), 32'd1);
    check("s_mem_addr",  mem_addr,    32'h0000_0100);
    check("s_mem_wdata", mem_wdata,   32'hDEAD_BEEF);
    check("s_busy_t0",   32'(busy),   32'd0);
    cyc(); dm_req = 1'b0; dm_we = 1'b0; #1;
    check("s_busy_t1",   32'(busy),   32'd1);
    check("s_dm_gnt_t1", 32'(dm_gnt), 32'd0);
    cyc(); #1;
    check("s_busy_t2",   32'(busy),      32'd1);
    check("s_dm_rvalid", 32'(dm_rvalid), 32'd1);
    check("s_if_rvalid", 32'(if_rvalid), 32'd0);

    // 4/5. contention: DM,DM,DM,DM,IF,DM with grants every 3 cycles
    cyc(); if_req = 1'b1; dm_req = 1'b1; dm_addr = 32'h0000_0300;
    if_addr = 32'h0000_0044; mem_rdata = 32'h1234_5678; #1;
    for (int k = 0; k < 18; k++) begin
      if (k > 0) cyc();
      #1;
      check($sformatf("c%0d_if_gnt", k), 32'(if_gnt),
            32'((k % 3 == 0) && (k / 3 == 4)));
      check($sformatf("c%0d_dm_gnt", k), 32'(dm_gnt),
            32'((k % 3 == 0) && (k / 3 != 4)));
      check($sformatf("c%0d_busy", k), 32'(busy), 32'(k % 3 != 0));
      check($sformatf("c%0d_if_rvalid", k), 32'(if_rvalid),
            32'((k % 3 == 2) && (k / 3 == 4)));
      check($sformatf("c%0d_dm_rvalid", k), 32'(dm_rvalid),
            32'((k % 3 == 2) && (k / 3 != 4)));
    end
    check("c_dm_rdata", dm_rdata, 32'h1234_5678);

    cyc(); if_req = 1'b0; dm_req = 1'b0; mem_rdata = 32'h0; #1;
    check("idle_mem_en", 32'(mem_en), 32'd0);
    check("idle_busy",   32'(busy),   32'd0);

    // 6. mid-access reset
    cyc(); dm_req = 1'b1; dm_addr = 32'h0000_0400; #1;
    check("mr_dm_gnt", 32'(dm_gnt), 32'd1);
    cyc(); dm_req = 1'b0; reset = 1'b0; #1;
    check("mr_busy_t1",   32'(busy),      32'd0);
    check("mr_rvalid_t1", 32'(dm_rvalid), 32'd0);
    cyc(); #1;
    check("mr_rvalid_t2", 32'(dm_rvalid), 32'd0);
    check("mr_mem_en_t2", 32'(mem_en),    32'd0);
    check("mr_busy_t2",   32'(busy),      32'd0);
    cyc(); reset = 1'b1; if_req = 1'b1; if_addr = 32'h0000_0080; #1;
    check("mr_if_gnt",   32'(if_gnt), 32'd1);
    check("mr_mem_addr", mem_addr,    32'h0000_0080);
    cyc(); if_req = 1'b0; #1;
    check("mr_busy",      32'(busy),      32'd1);
    check("mr_if_rv_t1",  32'(if_rvalid), 32'd0);
    cyc(); #1;
    check("mr_if_rvalid", 32'(if_rvalid), 32'd1);
    check("mr_dm_rvalid", 32'(dm_rvalid), 32'd0);
    cyc(); #1;
    check("mr_end_busy",  32'(busy),      32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
